// File: rtl/audio_sample_fifo.sv
// audio_sample_fifo: single-clock FWFT buffer for stereo audio samples feeding i2s_controller.
// An empty buffer presents silence (all zeros) on fifo_data.
// Optional feature macro: AUDIO_FIFO_STATS_EN enables the saturating overflow/underrun counters.
module audio_sample_fifo #(
  parameter int unsigned DATA_WIDTH  = 48,
  parameter int unsigned ADDR_WIDTH  = 4,
  parameter int unsigned AFULL_LEVEL = 12
) (
  input  logic                  clk,
  input  logic                  aresetn,
  input  logic                  flush,
  input  logic                  clear_stats,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_wr,
  input  logic                  fifo_rd,
  output logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_empty,
  output logic                  fifo_full,
  output logic                  fifo_afull,
  output logic [ADDR_WIDTH:0]   fifo_level,
  output logic [15:0]           overflow_cnt,
  output logic [15:0]           underrun_cnt
);

  localparam int unsigned DEPTH   = 2 ** ADDR_WIDTH;
  localparam int unsigned LVL_W   = ADDR_WIDTH + 1;
  localparam int unsigned CNT_W   = 16;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [LVL_W-1:0]      level;
  logic                  wr_acc;
  logic                  rd_acc;

  // Status decoded straight from the registered level
  assign fifo_level = level;
  assign fifo_empty = (level == '0);
  assign fifo_full  = (level == LVL_W'(DEPTH));
  assign fifo_afull = (level >= LVL_W'(AFULL_LEVEL));
  assign fifo_data  = fifo_empty ? '0 : mem[rd_ptr];

  // A full buffer still accepts a write when a read frees a slot in the same cycle
  assign rd_acc = fifo_rd & ~fifo_empty & ~flush;
  assign wr_acc = data_wr & (~fifo_full | fifo_rd) & ~flush;

  // Sample storage, intentionally not reset
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= data_in;
    end
  end

  // Pointers and occupancy
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      if (rd_acc) rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
      if (wr_acc && !rd_acc)      level <= level + LVL_W'(1);
      else if (rd_acc && !wr_acc) level <= level - LVL_W'(1);
    end
  end

`ifdef AUDIO_FIFO_STATS_EN
  logic ovf_evt;
  logic unr_evt;

  assign ovf_evt = data_wr & fifo_full & ~fifo_rd & ~flush;
  assign unr_evt = fifo_rd & fifo_empty & ~flush;

  // Saturating event counters; clear wins over a same-cycle increment
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      overflow_cnt <= '0;
      underrun_cnt <= '0;
    end else if (clear_stats) begin
      overflow_cnt <= '0;
      underrun_cnt <= '0;
    end else begin
      if (ovf_evt && overflow_cnt != '1) overflow_cnt <= overflow_cnt + CNT_W'(1);
      if (unr_evt && underrun_cnt != '1) underrun_cnt <= underrun_cnt + CNT_W'(1);
    end
  end
`else
  logic unused_clear_stats;

  assign unused_clear_stats = clear_stats;
  assign overflow_cnt       = '0;
  assign underrun_cnt       = '0;
`endif

endmodule

// File: tb/tb_audio_sample_fifo.sv
// Self-checking bench for audio_sample_fifo: directed scenarios plus randomized traffic,
// compared every cycle against a queue-based reference model.
module tb_audio_sample_fifo;

  localparam int unsigned DW    = 48;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AFULL = 12;

  logic          clk = 1'b0;
  logic          aresetn = 1'b0;
  logic          flush = 1'b0;
  logic          clear_stats = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          data_wr = 1'b0;
  logic          fifo_rd = 1'b0;
  logic [DW-1:0] fifo_data;
  logic          fifo_empty;
  logic          fifo_full;
  logic          fifo_afull;
  logic [4:0]    fifo_level;
  logic [15:0]   overflow_cnt;
  logic [15:0]   underrun_cnt;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  logic [DW-1:0] q [$];
  int unsigned   m_ovf = 0;
  int unsigned   m_unr = 0;

  audio_sample_fifo dut (
    .clk          (clk),
    .aresetn      (aresetn),
    .flush        (flush),
    .clear_stats  (clear_stats),
    .data_in      (data_in),
    .data_wr      (data_wr),
    .fifo_rd      (fifo_rd),
    .fifo_data    (fifo_data),
    .fifo_empty   (fifo_empty),
    .fifo_full    (fifo_full),
    .fifo_afull   (fifo_afull),
    .fifo_level   (fifo_level),
    .overflow_cnt (overflow_cnt),
    .underrun_cnt (underrun_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Compare every DUT output against the reference model
  task automatic check_all(input string where);
    logic [DW-1:0] exp_data;
    int unsigned   n;
    n = q.size();
    exp_data = (n != 0) ? q[0] : '0;
    check({where, ".data"},  64'(fifo_data),  64'(exp_data));
    check({where, ".level"}, 64'(fifo_level), 64'(n));
    check({where, ".empty"}, 64'(fifo_empty), 64'(n == 0));
    check({where, ".full"},  64'(fifo_full),  64'(n == DEPTH));
    check({where, ".afull"}, 64'(fifo_afull), 64'(n >= AFULL));
`ifdef AUDIO_FIFO_STATS_EN
    check({where, ".ovf"},   64'(overflow_cnt), 64'(m_ovf));
    check({where, ".unr"},   64'(underrun_cnt), 64'(m_unr));
`else
    check({where, ".ovf"},   64'(overflow_cnt), 64'(0));
    check({where, ".unr"},   64'(underrun_cnt), 64'(0));
`endif
  endtask

  // One clock with the given inputs; the model applies the buffer rules to a queue
  task automatic cycle(input string where, input logic wr, input logic rd,
                       input logic [DW-1:0] d, input logic fl, input logic cs);
    int unsigned n;
    bit ovf, unr;
    data_wr = wr; fifo_rd = rd; data_in = d; flush = fl; clear_stats = cs;
    n = q.size();
    ovf = 1'b0; unr = 1'b0;
    if (fl) begin
      q.delete();
    end else begin
      ovf = wr && (n == DEPTH) && !rd;
      unr = rd && (n == 0);
      if (rd && n != 0) void'(q.pop_front());
      if (wr && !ovf) q.push_back(d);
    end
    if (cs) begin
      m_ovf = 0; m_unr = 0;
    end else begin
      if (ovf && m_ovf != 32'hFFFF) m_ovf++;
      if (unr && m_unr != 32'hFFFF) m_unr++;
    end
    @(posedge clk);
    #1;
    check_all(where);
  endtask

  function automatic logic [DW-1:0] rnd_word();
    return DW'({$urandom(), $urandom()});
  endfunction

  // Async reset applied mid-cycle; outputs must clear without waiting for a clock
  task automatic async_reset(input string where);
    #3;
    aresetn = 1'b0;
    data_wr = 1'b0; fifo_rd = 1'b0; flush = 1'b0; clear_stats = 1'b0;
    q.delete(); m_ovf = 0; m_unr = 0;
    #1;
    check_all(where);
    repeat (2) @(posedge clk);
    @(negedge clk);
    aresetn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int unsigned wp, rp;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    aresetn = 1'b1;
    @(posedge clk);
    #1;
    check_all("post_reset");

    // Single word through and back to silence
    cycle("s1_wr", 1, 0, 48'h000001FFFFFF, 0, 0);
    cycle("s1_rd", 0, 1, '0, 0, 0);

    // Fill to full, overflow once, drain in order
    for (int i = 1; i <= 16; i++) cycle("s2_fill", 1, 0, DW'(i), 0, 0);
    cycle("s2_ovf", 1, 0, DW'(17), 0, 0);
    for (int i = 1; i <= 16; i++) begin
      check("s2_order", 64'(fifo_data), 64'(i));
      cycle("s2_drain", 0, 1, '0, 0, 0);
    end

    // Underruns then stats clear
    repeat (3) cycle("s3_unr", 0, 1, '0, 0, 0);
    cycle("s3_clr", 0, 0, '0, 0, 1);

    // Full buffer with simultaneous wr/rd across pointer wrap
    for (int i = 0; i < 16; i++) cycle("s4_fill", 1, 0, rnd_word(), 0, 0);
    for (int i = 0; i < 40; i++) cycle("s4_wrrd", 1, 1, rnd_word(), 0, 0);
    cycle("s4_wr_empty_rd", 0, 0, '0, 1, 0);
    cycle("s4_wrrd_empty", 1, 1, rnd_word(), 0, 0);

    // Flush priority, then reset in the middle of a burst
    for (int i = 0; i < 5; i++) cycle("s5_load", 1, 0, rnd_word(), 0, 0);
    cycle("s5_flush", 1, 1, rnd_word(), 1, 0);
    for (int i = 0; i < 6; i++) cycle("s5_burst", 1, 0, rnd_word(), 0, 0);
    async_reset("s5_areset");
    check_all("s5_after_reset");
    cycle("s5_first_rd", 0, 1, '0, 0, 0);

    // Randomized traffic in phases with varied write/read bias
    for (int ph = 0; ph < 8; ph++) begin
      wp = $urandom_range(90, 10);
      rp = $urandom_range(90, 10);
      for (int i = 0; i < 250; i++) begin
        cycle("rand",
              ($urandom_range(99) < wp),
              ($urandom_range(99) < rp),
              rnd_word(),
              ($urandom_range(63) == 0),
              ($urandom_range(99) == 0));
      end
    end
    async_reset("rand_areset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
